mealy_reg_seq_detector: RTL and testbench



---
 rtl/mealy_det_pkg.sv | 56 +++++
 rtl/mealy_det_next.sv | 57 +++++
 rtl/mealy_reg_seq_detector.sv | 45 ++++
 tb/tb_mealy_reg_seq_detector.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mealy_det_pkg.sv
// Elaboration-time helpers for the serial pattern detector: state-width
// calculation and KMP-style failure / next-state evaluation over a pattern
// whose first-received bit sits at the MSB (bit len-1).
package mealy_det_pkg;

  localparam int unsigned MAX_LEN = 16;

  // Ceiling log2, minimum result 1 so a 2-bit pattern still gets a state bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // i-th received bit of the pattern (0 = first bit on the wire)
  function automatic logic pbit(input logic [MAX_LEN-1:0] p, input int unsigned len,
                                input int unsigned i);
    return p[len-1-i];
  endfunction

  // Longest proper prefix of the first k pattern bits that is also their suffix
  function automatic int unsigned failure(input logic [MAX_LEN-1:0] p, input int unsigned len,
                                          input int unsigned k);
    int unsigned f;
    logic        ok;
    f = 0;
    for (int unsigned m = 1; m < MAX_LEN; m++) begin
      if (m < k) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < MAX_LEN; j++) begin
          if (j < m && pbit(p, len, j) != pbit(p, len, k - m + j)) ok = 1'b0;
        end
        if (ok) f = m;
      end
    end
    return f;
  endfunction

  // Matched-prefix length after seeing bit b in state k; a full match
  // folds back to the failure value of the whole pattern.
  function automatic int unsigned next_state(input logic [MAX_LEN-1:0] p, input int unsigned len,
                                             input int unsigned k, input logic b);
    int unsigned m;
    m = k;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (m > 0 && pbit(p, len, m) != b) m = failure(p, len, m);
    end
    if (pbit(p, len, m) == b) m = m + 1;
    if (m == len) m = failure(p, len, len);
    return m;
  endfunction

endpackage

// File: rtl/mealy_det_next.sv
// Combinational next-state and hit decode for the sequence detector.
// Both are constant tables built at elaboration; no runtime table memory.
module mealy_det_next
  import mealy_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1001,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          SW      = clog2(PAT_LEN)
) (
  input  logic [SW-1:0] state,
  input  logic          x,
  output logic [SW-1:0] nxt,
  output logic          hit
);

  localparam int unsigned NST = 2 ** SW;

  logic [SW-1:0] nx0 [NST];
  logic [SW-1:0] nx1 [NST];
  logic          ht0 [NST];
  logic          ht1 [NST];

  // Unused codes (PAT_LEN not a power of 2) decode to state 0 with no hit
  for (genvar s = 0; s < NST; s++) begin : g_tbl
    if (s < PAT_LEN) begin : g_live
      localparam bit H0 = (s == PAT_LEN - 1) && (PATTERN[PAT_LEN-1-s] == 1'b0);
      localparam bit H1 = (s == PAT_LEN - 1) && (PATTERN[PAT_LEN-1-s] == 1'b1);
      localparam int unsigned N0 = (H0 && !OVERLAP) ? 0 :
                                   next_state(16'(PATTERN), PAT_LEN, s, 1'b0);
      localparam int unsigned N1 = (H1 && !OVERLAP) ? 0 :
                                   next_state(16'(PATTERN), PAT_LEN, s, 1'b1);
      assign nx0[s] = SW'(N0);
      assign nx1[s] = SW'(N1);
      assign ht0[s] = H0;
      assign ht1[s] = H1;
    end else begin : g_dead
      assign nx0[s] = '0;
      assign nx1[s] = '0;
      assign ht0[s] = 1'b0;
      assign ht1[s] = 1'b0;
    end
  end

  // Next-state selection from the elaborated transition table
  always_comb begin
    nxt = '0;
    nxt = x ? nx1[state] : nx0[state];
  end

  // Mealy hit: final pattern bit matches in the last state
  always_comb begin
    hit = 1'b0;
    hit = x ? ht1[state] : ht0[state];
  end

endmodule

// File: rtl/mealy_reg_seq_detector.sv
// Serial sequence detector: Mealy FSM whose hit is registered onto y so the
// detect pulse is glitch-free and appears one clock after the final bit.
module mealy_reg_seq_detector
  import mealy_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  localparam int unsigned SW = clog2(PAT_LEN);

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic          hit;

  mealy_det_next #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_next (
    .state (state),
    .x     (x),
    .nxt   (nxt),
    .hit   (hit)
  );

  // State and registered detect; reset drops any hit pending on that edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
      y     <= 1'b0;
    end else begin
      state <= nxt;
      y     <= hit;
    end
  end

endmodule

// File: tb/tb_mealy_reg_seq_detector.sv
// Bench for mealy_reg_seq_detector: three instances (1001 overlap, 1001
// non-overlap, 111 overlap) share one stimulus stream; a history-window
// model predicts y for each and a queue carries expectations to the check.
module tb_mealy_reg_seq_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x   = 1'b0;
  logic [2:0] yv;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mealy_reg_seq_detector u_def (
    .clk (clk), .rst (rst), .x (x), .y (yv[0])
  );

  mealy_reg_seq_detector #(
    .PAT_LEN (4), .PATTERN (4'b1001), .OVERLAP (1'b0)
  ) u_novl (
    .clk (clk), .rst (rst), .x (x), .y (yv[1])
  );

  mealy_reg_seq_detector #(
    .PAT_LEN (3), .PATTERN (3'b111), .OVERLAP (1'b1)
  ) u_ones (
    .clk (clk), .rst (rst), .x (x), .y (yv[2])
  );

  // Model configuration per instance
  int unsigned  mlen [3] = '{4, 4, 3};
  logic [15:0]  mpat [3] = '{16'h0009, 16'h0009, 16'h0007};
  bit           movl [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0]  hist [3] = '{16'h0, 16'h0, 16'h0};
  int unsigned  cnt  [3] = '{0, 0, 0};
  int unsigned  pulses [3] = '{0, 0, 0};

  logic [2:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  // Drive one bit (or reset cycle), predict, then check after the edge
  task automatic step(input string tag, input logic r, input logic b);
    logic [2:0]  e;
    logic [15:0] mask;
    e = '0;
    @(negedge clk);
    rst = r;
    x   = b;
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        cnt[i]  = 0;
        hist[i] = '0;
      end else begin
        hist[i] = {hist[i][14:0], b};
        cnt[i]++;
        mask = (16'h1 << mlen[i]) - 16'h1;
        if (cnt[i] >= mlen[i] && (hist[i] & mask) == mpat[i]) begin
          e[i] = 1'b1;
          if (!movl[i]) cnt[i] = 0;
        end
      end
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.y%0d", tag, i), 32'(yv[i]), 32'(e[i]));
      pulses[i] += 32'(yv[i]);
    end
  endtask

  task automatic stream(input string tag, input int unsigned n, input logic [31:0] bits);
    for (int unsigned i = 0; i < n; i++) step(tag, 1'b1, bits[n-1-i]);
  endtask

  initial begin
    // Reset held with x toggling
    step("rst0", 1'b0, 1'b1);
    step("rst1", 1'b0, 1'b0);
    chk("rst.state", 32'(u_def.state), 32'd0);

    clr_pulses();
    stream("basic", 4, 32'b1001);
    chk("basic.count", pulses[0], 32'd1);

    step("rstA", 1'b0, 1'b0);
    clr_pulses();
    stream("long", 20, 32'b0011_0010_0001_0000_1001);
    chk("long.count", pulses[0], 32'd2);

    step("rstB", 1'b0, 1'b0);
    clr_pulses();
    stream("ovl", 7, 32'b1001001);
    chk("ovl.count", pulses[0], 32'd2);
    chk("novl.count", pulses[1], 32'd1);

    step("rstC", 1'b0, 1'b0);
    clr_pulses();
    stream("near1", 6, 32'b101001);
    chk("near1.count", pulses[0], 32'd1);

    step("rstD", 1'b0, 1'b0);
    clr_pulses();
    stream("near2", 5, 32'b10001);
    chk("near2.count", pulses[0], 32'd0);

    // Reset coincident with the completing bit suppresses the hit
    step("rstE", 1'b0, 1'b0);
    clr_pulses();
    stream("mid", 3, 32'b100);
    step("midrst", 1'b0, 1'b1);
    stream("after", 3, 32'b001);
    chk("mid.count", pulses[0], 32'd0);

    step("rstF", 1'b0, 1'b0);
    clr_pulses();
    stream("ones", 6, 32'b111111);
    chk("ones.count", pulses[2], 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
